// File: rtl/tinyqv_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tinyqv_prefetch_queue
//
// Instruction prefetch queue for the TinyQV core. It buffers 16-bit halfwords
// streamed by the QSPI instruction fetch engine. It presents the next complete
// RV32C (one halfword) or RV32 (two halfwords) instruction to the decoder,
// together with that instruction's halfword PC.
//
// The queue is a circular buffer of DEPTH halfwords. The read and write
// pointers carry one extra wrap bit, so count = wr - rd distinguishes full
// from empty. A redirect (branch/jump/ret) empties the queue, retargets both
// PCs and stops the fetch engine. The engine is then asked to restart at the
// new address.
//
// Parameters
//   DEPTH       halfword entries (power of 2, >= 4)
//   ADDR_BITS   halfword address width
//   RESET_ADDR  halfword address fetched first after reset
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   redirect        flush the queue and restart fetching at redirect_addr
//   redirect_addr   new halfword PC
//   fetch_addr      halfword address of the next halfword to be written
//   fetch_restart   ask the fetch engine to (re)start at fetch_addr
//   fetch_stall     fetch engine must not deliver its next halfword
//   fetch_started   fetch engine has begun streaming
//   fetch_stopped   fetch engine has stopped streaming
//   fetch_data      halfword from memory, valid when fetch_ready
//   fetch_ready     fetch_data valid this cycle
//   instr           {hw[rd+1], hw[rd]}; upper half meaningless for 16-bit instrs
//   instr_pc        halfword PC of instr
//   instr_len       2'b01 = 16-bit, 2'b10 = 32-bit
//   instr_avail     all halfwords of instr are present
//   instr_consume   decoder takes instr; queue advances by instr_len
//   level           halfwords currently held
//   overflow        sticky: a halfword arrived while the queue was full
// -----------------------------------------------------------------------------
module tinyqv_prefetch_queue #(
   parameter int DEPTH      = 8,
   parameter int ADDR_BITS  = 23,
   parameter int RESET_ADDR = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       redirect,
   input  logic [ADDR_BITS-1:0]       redirect_addr,
   output logic [ADDR_BITS-1:0]       fetch_addr,
   output logic                       fetch_restart,
   output logic                       fetch_stall,
   input  logic                       fetch_started,
   input  logic                       fetch_stopped,
   input  logic [15:0]                fetch_data,
   input  logic                       fetch_ready,
   output logic [31:0]                instr,
   output logic [ADDR_BITS-1:0]       instr_pc,
   output logic [1:0]                 instr_len,
   output logic                       instr_avail,
   input  logic                       instr_consume,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   typedef enum logic {
      STOPPED = 1'b0,
      RUNNING = 1'b1
   } fetch_state_e;

   fetch_state_e state, state_next;

   logic [15:0]          mem [DEPTH];
   logic [PTR_W-1:0]     rd, wr;
   logic [PTR_W-1:0]     rd_plus1;
   logic [PTR_W-1:0]     count;
   logic [PTR_W-1:0]     len_ext;
   logic [PTR_W-1:0]     level_next;
   logic                 full;
   logic                 write_en;
   logic                 drop_en;
   logic                 consume_en;
   logic [15:0]          hw_lo, hw_hi;

   // ---------------------------------------------------------------------------
   // Occupancy and read side (combinational from registers)
   // ---------------------------------------------------------------------------
   assign count    = wr - rd;
   assign full     = (count == PTR_W'(DEPTH));
   assign level    = count;
   assign rd_plus1 = rd + PTR_W'(1);

   // Only the low IDX_W bits index the array, so a 32-bit instruction whose
   // first half sits in the last entry takes its second half from entry 0.
   assign hw_lo = mem[rd[IDX_W-1:0]];
   assign hw_hi = mem[rd_plus1[IDX_W-1:0]];
   assign instr = {hw_hi, hw_lo};

   assign instr_len   = (hw_lo[1:0] == 2'b11) ? 2'b10 : 2'b01;
   assign len_ext     = {{(PTR_W-2){1'b0}}, instr_len};
   assign instr_avail = (count >= len_ext);

   // ---------------------------------------------------------------------------
   // Write/consume qualification. A redirect discards both the incoming
   // halfword and any consume in the same cycle.
   // ---------------------------------------------------------------------------
   assign write_en   = !rst && !redirect && fetch_ready && (state == RUNNING) && !full;
   assign drop_en    = !rst && !redirect && fetch_ready && (state == RUNNING) && full;
   assign consume_en = !rst && !redirect && instr_consume && instr_avail;

   // The stall looks at next cycle's occupancy. The engine therefore sees it
   // while the halfword that fills the queue is still in flight, and it stops
   // before any overrun.
   always_comb begin
      // NOTE: every signal driven here gets a default first; a path that
      // leaves it unassigned would infer a latch.
      level_next = count;
      if (rst || redirect) begin
         level_next = '0;
      end else begin
         if (write_en)   level_next = level_next + PTR_W'(1);
         if (consume_en) level_next = level_next - len_ext;
      end
   end

   assign fetch_stall = (level_next >= PTR_W'(DEPTH));

   // ---------------------------------------------------------------------------
   // Fetch engine handshake FSM
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next    = state;
      fetch_restart = 1'b0;
      case (state)
         STOPPED: begin
            fetch_restart = 1'b1;
            if (fetch_started) state_next = RUNNING;
         end
         RUNNING: begin
            if (fetch_stopped) state_next = STOPPED;
         end
         default: state_next = STOPPED;
      endcase
      // A redirect pulses fetch_restart low for one cycle. The engine
      // therefore sees a fresh restart request at the new address, even when
      // it was already waiting to start.
      if (redirect) begin
         state_next    = STOPPED;
         fetch_restart = 1'b0;
      end
      if (rst) fetch_restart = 1'b0;
   end

   // ---------------------------------------------------------------------------
   // Control state
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values from before the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= STOPPED;
         rd         <= '0;
         wr         <= '0;
         instr_pc   <= ADDR_BITS'(RESET_ADDR);
         fetch_addr <= ADDR_BITS'(RESET_ADDR);
         overflow   <= 1'b0;
      end else begin
         state <= state_next;
         if (redirect) begin
            rd         <= wr;
            instr_pc   <= redirect_addr;
            fetch_addr <= redirect_addr;
         end else begin
            if (write_en) begin
               wr         <= wr + PTR_W'(1);
               fetch_addr <= fetch_addr + ADDR_BITS'(1);
            end
            if (drop_en) overflow <= 1'b1;
            if (consume_en) begin
               rd       <= rd + len_ext;
               instr_pc <= instr_pc + {{(ADDR_BITS-2){1'b0}}, instr_len};
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Halfword storage
   // ---------------------------------------------------------------------------
   // NOTE: the array has no reset. Entries are read only when count says they
   // are valid, and leaving out the reset allows plain register or RAM
   // mapping.
   always_ff @(posedge clk) begin
      if (write_en) mem[wr[IDX_W-1:0]] <= fetch_data;
   end

endmodule

// File: tb/tb_tinyqv_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_tinyqv_prefetch_queue
//
// Directed bench for tinyqv_prefetch_queue with DEPTH=8, ADDR_BITS=23 and
// RESET_ADDR=0x100. Every halfword driven into the queue is pushed onto a
// scoreboard queue. When the DUT presents an instruction, the expected
// instruction, length and PC come from the head of that queue and from a
// bench-side PC. Inputs change 1 time unit after a rising edge. Outputs are
// checked 1 time unit later, well before the next edge.
// -----------------------------------------------------------------------------
module tb_tinyqv_prefetch_queue;

   localparam int DEPTH      = 8;
   localparam int ADDR_BITS  = 23;
   localparam int RESET_ADDR = 'h100;
   localparam int LVL_W      = $clog2(DEPTH) + 1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 redirect;
   logic [ADDR_BITS-1:0] redirect_addr;
   logic [ADDR_BITS-1:0] fetch_addr;
   logic                 fetch_restart;
   logic                 fetch_stall;
   logic                 fetch_started;
   logic                 fetch_stopped;
   logic [15:0]          fetch_data;
   logic                 fetch_ready;
   logic [31:0]          instr;
   logic [ADDR_BITS-1:0] instr_pc;
   logic [1:0]           instr_len;
   logic                 instr_avail;
   logic                 instr_consume;
   logic [LVL_W-1:0]     level;
   logic                 overflow;

   int checks = 0;
   int errors = 0;

   logic [15:0]          hw_q[$];    // scoreboard: halfwords expected in the queue
   logic [ADDR_BITS-1:0] exp_pc;
   logic [ADDR_BITS-1:0] exp_faddr;
   logic                 exp_ovf;

   always #5 clk = ~clk;

   tinyqv_prefetch_queue #(
      .DEPTH      (DEPTH),
      .ADDR_BITS  (ADDR_BITS),
      .RESET_ADDR (RESET_ADDR)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .fetch_addr    (fetch_addr),
      .fetch_restart (fetch_restart),
      .fetch_stall   (fetch_stall),
      .fetch_started (fetch_started),
      .fetch_stopped (fetch_stopped),
      .fetch_data    (fetch_data),
      .fetch_ready   (fetch_ready),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_len     (instr_len),
      .instr_avail   (instr_avail),
      .instr_consume (instr_consume),
      .level         (level),
      .overflow      (overflow)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one halfword while RUNNING. Stall and overflow behaviour comes
   // from the scoreboard occupancy.
   task automatic push_hw(input logic [15:0] data);
      fetch_ready = 1'b1;
      fetch_data  = data;
      #1;
      check("stall_in_flight", fetch_stall, (hw_q.size() + 1 >= DEPTH));
      tick();
      fetch_ready = 1'b0;
      if (hw_q.size() < DEPTH) begin
         hw_q.push_back(data);
         exp_faddr = exp_faddr + 1'b1;
      end else begin
         exp_ovf = 1'b1;
      end
      #1;
      check("level_after_push", level, hw_q.size());
      check("fetch_addr", fetch_addr, exp_faddr);
      check("overflow", overflow, exp_ovf);
   endtask

   // Compare the head instruction against the scoreboard, then consume it.
   task automatic consume_check();
      logic [1:0] len;
      len = (hw_q[0][1:0] == 2'b11) ? 2'd2 : 2'd1;
      check("instr_avail", instr_avail, 1'b1);
      check("instr_len", instr_len, len);
      check("instr_pc", instr_pc, exp_pc);
      check("instr_lo", instr[15:0], hw_q[0]);
      if (len == 2'd2) check("instr_hi", instr[31:16], hw_q[1]);
      instr_consume = 1'b1;
      tick();
      instr_consume = 1'b0;
      for (int i = 0; i < int'(len); i++) void'(hw_q.pop_front());
      exp_pc = exp_pc + len;
      #1;
      check("level_after_consume", level, hw_q.size());
      check("pc_after_consume", instr_pc, exp_pc);
   endtask

   task automatic start_fetch();
      fetch_started = 1'b1;
      tick();
      fetch_started = 1'b0;
      #1;
      check("restart_low_running", fetch_restart, 1'b0);
   endtask

   initial begin
      rst = 1'b1; redirect = 1'b0; redirect_addr = '0;
      fetch_started = 1'b0; fetch_stopped = 1'b0;
      fetch_data = '0; fetch_ready = 1'b0; instr_consume = 1'b0;
      exp_pc = ADDR_BITS'(RESET_ADDR); exp_faddr = ADDR_BITS'(RESET_ADDR); exp_ovf = 1'b0;
      tick(); tick();

      // ---- Reset values ----
      check("restart_in_rst", fetch_restart, 1'b0);
      rst = 1'b0;
      #1;
      check("rst_restart", fetch_restart, 1'b1);
      check("rst_fetch_addr", fetch_addr, ADDR_BITS'(RESET_ADDR));
      check("rst_instr_pc", instr_pc, ADDR_BITS'(RESET_ADDR));
      check("rst_level", level, 0);
      check("rst_avail", instr_avail, 1'b0);
      check("rst_stall", fetch_stall, 1'b0);
      check("rst_overflow", overflow, 1'b0);

      // fetch_ready while STOPPED is ignored
      fetch_ready = 1'b1; fetch_data = 16'h1111;
      tick();
      fetch_ready = 1'b0;
      #1;
      check("stopped_ignore_level", level, 0);
      start_fetch();

      // ---- Two 16-bit instructions ----
      push_hw(16'h4501);
      push_hw(16'h0001);
      consume_check();
      consume_check();

      // ---- 32-bit instruction, consume before complete is ignored ----
      push_hw(16'h0513);
      check("partial_avail", instr_avail, 1'b0);
      instr_consume = 1'b1;
      tick();
      instr_consume = 1'b0;
      #1;
      check("ignored_consume_level", level, 1);
      check("ignored_consume_pc", instr_pc, exp_pc);
      push_hw(16'h00A0);
      check("instr32", instr, 32'h00A00513);
      consume_check();

      // ---- Fill to DEPTH, then one forced extra halfword ----
      for (int i = 0; i < DEPTH; i++) push_hw(16'h0001 | 16'(i << 4));
      check("full_overflow_clear", overflow, 1'b0);
      push_hw(16'hDEAD);   // dropped: scoreboard leaves it out
      check("full_level", level, DEPTH);

      // ---- Drain to 5, then redirect with colliding write/consume ----
      for (int i = 0; i < 3; i++) consume_check();
      check("pre_redirect_level", level, 5);
      redirect = 1'b1; redirect_addr = 23'h2000;
      fetch_ready = 1'b1; fetch_data = 16'h0001; instr_consume = 1'b1;
      #1;
      check("redirect_restart_low", fetch_restart, 1'b0);
      check("redirect_no_stall", fetch_stall, 1'b0);
      tick();
      redirect = 1'b0; fetch_ready = 1'b0; instr_consume = 1'b0;
      hw_q.delete();
      exp_pc = 23'h2000; exp_faddr = 23'h2000;
      #1;
      check("redir_level", level, 0);
      check("redir_avail", instr_avail, 1'b0);
      check("redir_restart_high", fetch_restart, 1'b1);
      check("redir_fetch_addr", fetch_addr, exp_faddr);
      check("redir_instr_pc", instr_pc, exp_pc);
      check("redir_overflow_sticky", overflow, 1'b1);
      start_fetch();

      // ---- 32-bit instruction straddling the array end ----
      // The write pointer is at entry 4 here. Three halfwords move the read
      // pointer to entry 7.
      for (int i = 0; i < 3; i++) push_hw(16'h0005);
      for (int i = 0; i < 3; i++) consume_check();
      push_hw(16'h0513);
      push_hw(16'h00A0);
      check("wrap_instr32", instr, 32'h00A00513);
      consume_check();

      // ---- Back-to-back redirects: the last one wins ----
      redirect = 1'b1; redirect_addr = 23'h3000;
      tick();
      check("b2b_restart_low1", fetch_restart, 1'b0);
      redirect_addr = 23'h3005;
      tick();
      redirect = 1'b0;
      exp_pc = 23'h3005; exp_faddr = 23'h3005;
      #1;
      check("b2b_restart_high", fetch_restart, 1'b1);
      check("b2b_fetch_addr", fetch_addr, exp_faddr);
      check("b2b_instr_pc", instr_pc, exp_pc);
      start_fetch();
      push_hw(16'h0009);

      // ---- Reset mid-stream with active inputs ----
      rst = 1'b1; fetch_ready = 1'b1; instr_consume = 1'b1;
      #1;
      check("midrst_restart", fetch_restart, 1'b0);
      tick();
      rst = 1'b0; fetch_ready = 1'b0; instr_consume = 1'b0;
      hw_q.delete();
      exp_pc = ADDR_BITS'(RESET_ADDR); exp_faddr = ADDR_BITS'(RESET_ADDR); exp_ovf = 1'b0;
      #1;
      check("midrst_level", level, 0);
      check("midrst_overflow", overflow, 1'b0);
      check("midrst_fetch_addr", fetch_addr, exp_faddr);
      check("midrst_instr_pc", instr_pc, exp_pc);
      check("midrst_restart_high", fetch_restart, 1'b1);
      start_fetch();

      // ---- Sustained write + consume of 16-bit instructions ----
      push_hw(16'h0101);
      for (int i = 0; i < 10; i++) begin
         logic [15:0] d;
         d = 16'h0201 + 16'(i << 8);
         fetch_ready = 1'b1; fetch_data = d; instr_consume = 1'b1;
         #1;
         check("sus_stall", fetch_stall, 1'b0);
         check("sus_pc", instr_pc, exp_pc);
         check("sus_instr", instr[15:0], hw_q[0]);
         tick();
         void'(hw_q.pop_front());
         hw_q.push_back(d);
         exp_pc = exp_pc + 1'b1;
         #1;
         check("sus_level", level, 1);
      end
      fetch_ready = 1'b0; instr_consume = 1'b0;
      #1;
      check("sus_overflow", overflow, 1'b0);

      // ---- Engine stops -> restart requested again ----
      fetch_stopped = 1'b1;
      tick();
      fetch_stopped = 1'b0;
      #1;
      check("stopped_restart", fetch_restart, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
